// File: rtl/toggle_updown_counter.sv
// Modulo-MOD up/down counter: a toggle-control stage computes which bits must
// flip, and a bank of toggle cells applies that vector on each rising edge.
// TC flags the terminal count for cascading; WRAP is its registered echo.
module toggle_updown_counter #(
    parameter int unsigned N   = 4,
    parameter int unsigned MOD = 10
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         UP,
    input  logic         LOAD,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic [N-1:0] T_VEC,
    output logic         TC,
    output logic         WRAP
);

    // One extra bit so MOD = 2^N is representable for the load range check.
    localparam int unsigned   NW    = N + 1;
    localparam logic [N-1:0]  Q_MAX = N'(MOD - 1);
    localparam logic [NW-1:0] MOD_W = NW'(MOD);

    logic [N-1:0] nxt;
    logic         d_in_range;
    logic         at_zero;
    logic         at_top;

    assign d_in_range = {1'b0, D} < MOD_W;
    assign at_zero    = (Q == '0);
    // Q >= MOD-1 also catches unreachable out-of-range values so they recover to 0.
    assign at_top     = (Q >= Q_MAX);

    // Next-state selection; the toggle vector is the set of bits that differ.
    always_comb begin
        nxt = Q;
        if (LOAD) begin
            nxt = d_in_range ? D : '0;
        end else if (EN) begin
            if (UP) begin
                nxt = at_top ? '0 : Q + N'(1);
            end else begin
                nxt = at_zero ? Q_MAX : Q - N'(1);
            end
        end
        T_VEC = Q ^ nxt;
        TC    = EN & ~LOAD & (UP ? (Q == Q_MAX) : at_zero);
    end

    // Toggle cells: each bit flips when its toggle enable is set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q <= '0;
        end else begin
            Q <= Q ^ T_VEC;
        end
    end

    // Wrap pulse: high for the single cycle after a terminal-count edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= TC;
        end
    end

endmodule

// File: tb/tb_toggle_updown_counter.sv
// Bench for toggle_updown_counter: a decade instance (MOD=10) and a full
// binary instance (MOD=16) share stimulus and are checked against an
// arithmetic reference model of the counting rules.
module tb_toggle_updown_counter;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       UP;
    logic       LOAD;
    logic [3:0] D;

    logic [3:0] q10, t10, q16, t16;
    logic       tc10, wrap10, tc16, wrap16;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mq10 = 0, mq16 = 0;
    int mw10 = 0, mw16 = 0;

    toggle_updown_counter #(.N(4), .MOD(10)) dut10 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(q10), .T_VEC(t10), .TC(tc10), .WRAP(wrap10)
    );

    toggle_updown_counter #(.N(4), .MOD(16)) dut16 (
        .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
        .Q(q16), .T_VEC(t16), .TC(tc16), .WRAP(wrap16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int model_next(int q, int m, bit en, bit up, bit ld, int d);
        if (ld) return (d < m) ? d : 0;
        if (!en) return q;
        if (up) return (q + 1 >= m) ? 0 : q + 1;
        return (q == 0) ? m - 1 : q - 1;
    endfunction

    function automatic int model_tc(int q, int m, bit en, bit up, bit ld);
        if (!en || ld) return 0;
        if (up) return (q == m - 1) ? 1 : 0;
        return (q == 0) ? 1 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic check_all(string tag);
        int   n10, n16;
        logic [3:0] chain;
        bit   all;
        n10 = model_next(mq10, 10, EN, UP, LOAD, int'(D));
        n16 = model_next(mq16, 16, EN, UP, LOAD, int'(D));
        chk({tag, ".q10"},    32'(q10),    32'(mq10));
        chk({tag, ".tvec10"}, 32'(t10),    32'(mq10 ^ n10));
        chk({tag, ".tc10"},   32'(tc10),   32'(model_tc(mq10, 10, EN, UP, LOAD)));
        chk({tag, ".wrap10"}, 32'(wrap10), 32'(mw10));
        chk({tag, ".q16"},    32'(q16),    32'(mq16));
        chk({tag, ".tvec16"}, 32'(t16),    32'(mq16 ^ n16));
        chk({tag, ".tc16"},   32'(tc16),   32'(model_tc(mq16, 16, EN, UP, LOAD)));
        chk({tag, ".wrap16"}, 32'(wrap16), 32'(mw16));
        if (!LOAD) begin
            for (int i = 0; i < 4; i++) begin
                all = 1'b1;
                for (int j = 0; j < i; j++) begin
                    if (UP && ((mq16 >> j) & 1) == 0) all = 1'b0;
                    if (!UP && ((mq16 >> j) & 1) == 1) all = 1'b0;
                end
                chain[i] = EN & all;
            end
            chk({tag, ".chain16"}, 32'(t16), 32'(chain));
        end
    endtask

    // Apply inputs, check before the edge, advance the model at the edge.
    task automatic cyc(string tag, bit en, bit up, bit ld, int d);
        int n10, n16;
        EN = en; UP = up; LOAD = ld; D = 4'(d);
        #1;
        check_all(tag);
        @(posedge CLK);
        n10  = model_next(mq10, 10, en, up, ld, d);
        n16  = model_next(mq16, 16, en, up, ld, d);
        mw10 = model_tc(mq10, 10, en, up, ld);
        mw16 = model_tc(mq16, 16, en, up, ld);
        mq10 = n10;
        mq16 = n16;
        @(negedge CLK);
    endtask

    initial begin
        int wraps;
        RST = 1'b0; EN = 1'b1; UP = 1'b1; LOAD = 1'b0; D = 4'd0;
        #3;
        check_all("reset");
        #19;
        RST = 1'b1;

        // Up count through the decade wrap
        for (int k = 0; k < 12; k++) cyc("up", 1, 1, 0, 0);

        // Down count from 0 through the 0->9 wrap
        cyc("load0", 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) cyc("down", 1, 0, 0, 0);

        // Load beats enable at terminal count
        cyc("load9", 0, 1, 1, 9);
        cyc("load_at_tc", 1, 1, 1, 5);
        cyc("after_load", 0, 1, 0, 0);
        cyc("load12", 0, 1, 1, 12);
        cyc("after_load12", 0, 1, 0, 0);

        // Hold at 7, then toggle vectors at 7->8 and 9->0
        cyc("load7", 0, 1, 1, 7);
        for (int k = 0; k < 3; k++) cyc("hold", 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc("up_tvec", 1, 1, 0, 0);

        // Async reset between edges at Q=6
        cyc("load5", 0, 1, 1, 5);
        cyc("to6", 1, 1, 0, 0);
        #2;
        RST = 1'b0;
        #1;
        chk("async_rst.q10",    32'(q10),    32'd0);
        chk("async_rst.wrap10", 32'(wrap10), 32'd0);
        chk("async_rst.q16",    32'(q16),    32'd0);
        chk("async_rst.wrap16", 32'(wrap16), 32'd0);
        mq10 = 0; mq16 = 0; mw10 = 0; mw16 = 0;
        RST = 1'b1;
        for (int k = 0; k < 3; k++) cyc("resume", 1, 1, 0, 0);

        // Full binary: 16 up edges return to 0 with one wrap pulse
        cyc("bin_load0", 0, 1, 1, 0);
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            cyc("bin_up", 1, 1, 0, 0);
            if (wrap16) wraps++;
        end
        chk("bin.wrap_count", 32'(wraps), 32'd1);
        chk("bin.q16_final",  32'(q16),   32'd0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            cyc("rand", 1'($urandom % 2), 1'($urandom % 2),
                ($urandom % 8) == 0, int'($urandom % 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toggle_updown_counter.md
# toggle_updown_counter

Synchronous modulo-MOD up/down counter built as a toggle-control stage driving a bank of toggle flip-flops. Each bit toggles on a clock edge when its toggle enable is high. The block computes the per-bit toggle vector, holds the count in toggle cells, and provides a terminal-count flag and a registered wrap pulse for cascading. Typical uses are decade/BCD counters and clock-enable dividers.

## Interface
- N, 4, counter width in bits
- MOD, 10, count modulus; legal range 2 ≤ MOD ≤ 2^N; count sequence is 0..MOD-1
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-low; clock CLK
- EN  input  1  count enable
- UP  input  1  direction: 1 = increment, 0 = decrement
- LOAD  input  1  synchronous parallel load
- D  input  N  load value
- Q  output  N  current count
- T_VEC  output  N  toggle vector applied to the toggle cells this cycle (combinational)
- TC  output  1  terminal count (combinational)
- WRAP  output  1  registered one-cycle pulse after a wrap-around

## Operation
- Storage: N toggle cells. Bit i is updated as Q[i] <= Q[i] ^ T_VEC[i].
- Next-state selection, in priority order:
  - RST low: asynchronous clear, overriding everything else.
  - LOAD = 1: next = D if D < MOD, else next = 0. LOAD overrides EN.
  - EN = 1, UP = 1: next = 0 if Q == MOD-1, else Q+1.
  - EN = 1, UP = 0: next = MOD-1 if Q == 0, else Q-1.
  - Otherwise: next = Q (hold).
- T_VEC = Q ^ next. It is all-zero when holding.
- When MOD = 2^N, the up/down case reduces to T_VEC[i] = EN & AND(Q[i-1:0]) for up, or EN & AND(~Q[i-1:0]) for down. The implementation may use this form, but the results must be identical.
- TC = EN & ~LOAD & (UP ? Q == MOD-1 : Q == 0).
- WRAP <= TC on each rising edge, so it is high for exactly the one cycle following a wrap transition.
- Out-of-range Q (≥ MOD) is unreachable through normal operation. If it does occur, an up count goes to 0, a down count goes to Q-1, and TC = 0.
- Arithmetic is N-bit unsigned. Increment and decrement never carry outside N bits, because the wrap logic intercepts both ends of the range.

## Timing
- Reset values: Q = 0, WRAP = 0. TC and T_VEC follow from Q = 0 and the current inputs.
- RST deassertion is synchronous to CLK by the surrounding design. The first count happens on the first rising edge at which RST = 1 and EN = 1.
- Latency: a single cycle. Q reflects EN/UP/LOAD/D sampled at edge k immediately after edge k.
- Changing UP mid-sequence takes effect at the next edge. There is no dead cycle.
- Simultaneous events:
  - LOAD with EN at terminal count: the load wins, TC = 0, and no WRAP follows.
  - RST asserted mid-count, including while WRAP is high: Q and WRAP clear immediately, without waiting for a clock edge.
- Cascading: feeding the TC of a lower stage to the EN of a higher stage forms a multi-digit counter with no added latency.

## Test plan
- Reset/count: hold RST = 0 for 22 time units, then release with EN = 1, UP = 1. Q steps 0,1,…,9,0. TC is high while Q = 9. WRAP is high for one cycle while Q = 0 after the wrap.
- Down wrap: starting from Q = 0, set EN = 1, UP = 0. Q goes 9,8,…,0,9. TC is high at Q = 0. WRAP pulses after the 0→9 transition.
- Load priority:
  - With Q = 9, EN = 1, UP = 1, pulse LOAD with D = 5. Q = 5 next cycle, and WRAP stays 0.
  - LOAD with D = 12 gives Q = 0.
- Hold and T_VEC:
  - With EN = 0 and Q = 7 for 3 cycles, Q stays 7 and T_VEC = 0000.
  - At Q = 7 with EN = 1, UP = 1, T_VEC = 1111 (7→8). At Q = 9 with EN = 1, UP = 1, T_VEC = 1001 (9→0).
- Async reset mid-operation: assert RST = 0 between clock edges while Q = 6. Q = 0 immediately. Deassert, and counting resumes 1,2,… from the next enabled edge.
- Full binary (N = 4, MOD = 16): up-count 16 cycles returns to Q = 0 with exactly one WRAP pulse. T_VEC matches the AND-chain form on every cycle.
